// File: rtl/mac_output_buffer.sv
// mac_output_buffer: circular FIFO that collects signed MAC accumulator
// results, applies an optional ReLU clamp on write, and presents the head
// entry to a ready/valid consumer. Inputs that arrive while the buffer is
// full are dropped and recorded in a sticky overflow flag.
module mac_output_buffer #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [WIDTH-1:0]    f_in,
    input  logic                       valid_in,
    input  logic                       relu_en,
    input  logic                       out_ready,
    output logic signed [WIDTH-1:0]    out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Clamp negative results to zero when ReLU is enabled; bit-exact otherwise.
    function automatic logic signed [WIDTH-1:0] relu_clamp(
        input logic signed [WIDTH-1:0] val,
        input logic                    en
    );
        if (en && val[WIDTH-1]) begin
            return '0;
        end
        return val;
    endfunction

    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic signed [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    overflow_q, overflow_d;

    logic full;
    logic push;
    logic pop;

    // Next-state: push/pop decisions use the pre-edge occupancy, so a full
    // buffer refuses a write even when a pop happens in the same cycle.
    always_comb begin
        full       = (count_q == FULL_CNT);
        push       = valid_in & ~full;
        pop        = (count_q != '0) & out_ready;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (valid_in & full);

        if (push) begin
            mem_d[wr_ptr_q] = relu_clamp(f_in, relu_en);
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers; reset clears storage too so out_data is never unknown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule
